sent_rx_pulse_decoder: RTL and testbench

Front-end of the SENT receiver. It synchronises the raw SENT line and measures falling-edge-to-falling-edge periods in SENT ticks. From those periods it recovers sync, status, data, CRC and optional pause pulses, then presents each complete frame to the downstream CRC-check/control stage as one registered parallel word with a single-cycle strobe. Protocol violations are flagged with an error code, and the decoder re-hunts for sync.

---
 rtl/sent_rx_pulse_decoder.sv | 233 +++++++++++++++++++++++
 tb/tb_sent_rx_pulse_decoder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sent_rx_pulse_decoder.sv
// SENT receiver front-end: synchronises the raw line, measures falling-edge periods in ticks
// and decodes sync/status/data/CRC/pause pulses into one registered frame word per strobe.
module sent_rx_pulse_decoder #(
    parameter int unsigned TICK_CLKS = 8,
    parameter int unsigned NIBBLES   = 6,
    parameter bit          PAUSE_EN  = 1'b1
) (
    input  logic                 clk_rx,
    input  logic                 reset_n_rx,
    input  logic                 sent_in,
    output logic                 frame_valid,
    output logic [3:0]           status_out,
    output logic [4*NIBBLES-1:0] data_out,
    output logic [3:0]           crc_out,
    output logic                 serial_bit2,
    output logic                 serial_bit3,
    output logic                 pause_valid,
    output logic [9:0]           pause_ticks,
    output logic                 frame_error,
    output logic [2:0]           error_code
);

    typedef enum logic [2:0] {S_IDLE, S_HUNT, S_STATUS, S_DATA, S_CRC, S_POST} state_t;

    localparam int unsigned   CW       = (TICK_CLKS > 1) ? $clog2(TICK_CLKS) : 1;
    localparam int unsigned   DW       = 4 * NIBBLES;
    localparam logic [CW-1:0] CLK_LAST = CW'(TICK_CLKS - 1);
    localparam logic [CW-1:0] CLK_HALF = CW'(TICK_CLKS / 2);
    localparam logic [2:0]    IDX_LAST = 3'(NIBBLES - 1);
    localparam logic [9:0]    TICK_MAX = 10'd1023;
    localparam logic [2:0]    ERR_NIBBLE  = 3'd1;
    localparam logic [2:0]    ERR_SYNC    = 3'd2;
    localparam logic [2:0]    ERR_TIMEOUT = 3'd3;
    localparam logic [2:0]    ERR_POST    = 3'd4;

    state_t          state_q, state_d;
    logic            s1_q, s1_d, s2_q, s2_d, s3_q, s3_d, fall_q, fall_d;
    logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
    logic [9:0]      tick_cnt_q, tick_cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [3:0]      status_sh_q, status_sh_d;
    logic [DW-1:0]   data_sh_q, data_sh_d;
    logic            frame_valid_q, frame_valid_d;
    logic [3:0]      status_out_q, status_out_d;
    logic [DW-1:0]   data_out_q, data_out_d;
    logic [3:0]      crc_out_q, crc_out_d;
    logic            serial_bit2_q, serial_bit2_d, serial_bit3_q, serial_bit3_d;
    logic            pause_valid_q, pause_valid_d;
    logic [9:0]      pause_ticks_q, pause_ticks_d;
    logic            frame_error_q, frame_error_d;
    logic [2:0]      error_code_q, error_code_d;

    logic            clk_wrap, timeout, is_sync, is_nib, is_pause;
    logic [CW-1:0]   clk_inc;
    logic [9:0]      tick_inc, p;
    logic [10:0]     p_sum;
    logic [3:0]      nib;

    always_comb begin
        s1_d   = sent_in;
        s2_d   = s1_q;
        s3_d   = s2_q;
        fall_d = s3_q & ~s2_q;

        // Period is taken from the counter value this cycle would produce, so the edge cycle
        // itself counts and the measured length equals the edge-to-edge distance in clocks.
        clk_wrap = (clk_cnt_q == CLK_LAST);
        clk_inc  = clk_wrap ? '0 : clk_cnt_q + CW'(1);
        tick_inc = (clk_wrap && (tick_cnt_q != TICK_MAX)) ? tick_cnt_q + 10'd1 : tick_cnt_q;
        p_sum    = {1'b0, tick_inc} + ((clk_inc >= CLK_HALF) ? 11'd1 : 11'd0);
        p        = p_sum[10] ? TICK_MAX : p_sum[9:0];

        is_sync  = (p == 10'd56);
        is_nib   = (p >= 10'd12) && (p <= 10'd27);
        nib      = 4'(p - 10'd12);
        is_pause = PAUSE_EN && (p >= 10'd12) && (p <= 10'd768) && !is_sync;
        timeout  = (state_q != S_IDLE) && clk_wrap && (tick_cnt_q == TICK_MAX - 10'd1);

        state_d       = state_q;
        idx_d         = idx_q;
        status_sh_d   = status_sh_q;
        data_sh_d     = data_sh_q;
        frame_valid_d = 1'b0;
        status_out_d  = status_out_q;
        data_out_d    = data_out_q;
        crc_out_d     = crc_out_q;
        serial_bit2_d = serial_bit2_q;
        serial_bit3_d = serial_bit3_q;
        pause_valid_d = 1'b0;
        pause_ticks_d = pause_ticks_q;
        frame_error_d = 1'b0;
        error_code_d  = error_code_q;

        if (state_q == S_IDLE) begin
            clk_cnt_d  = '0;
            tick_cnt_d = '0;
        end else begin
            clk_cnt_d  = clk_inc;
            tick_cnt_d = tick_inc;
        end

        if (fall_q) begin
            clk_cnt_d  = '0;
            tick_cnt_d = '0;
            case (state_q)
                S_IDLE: state_d = S_HUNT;
                S_HUNT: if (is_sync) state_d = S_STATUS;
                S_STATUS: begin
                    if (is_nib) begin
                        status_sh_d = nib;
                        idx_d       = '0;
                        state_d     = S_DATA;
                    end else if (is_sync) begin
                        frame_error_d = 1'b1;
                        error_code_d  = ERR_SYNC;
                    end else begin
                        frame_error_d = 1'b1;
                        error_code_d  = ERR_NIBBLE;
                        state_d       = S_HUNT;
                    end
                end
                S_DATA: begin
                    if (is_nib) begin
                        data_sh_d = (data_sh_q << 4) | DW'(nib);
                        idx_d     = idx_q + 3'd1;
                        if (idx_q == IDX_LAST) state_d = S_CRC;
                    end else if (is_sync) begin
                        frame_error_d = 1'b1;
                        error_code_d  = ERR_SYNC;
                        state_d       = S_STATUS;
                    end else begin
                        frame_error_d = 1'b1;
                        error_code_d  = ERR_NIBBLE;
                        state_d       = S_HUNT;
                    end
                end
                S_CRC: begin
                    if (is_nib) begin
                        crc_out_d     = nib;
                        status_out_d  = status_sh_q;
                        data_out_d    = data_sh_q;
                        serial_bit2_d = status_sh_q[2];
                        serial_bit3_d = status_sh_q[3];
                        frame_valid_d = 1'b1;
                        state_d       = S_POST;
                    end else begin
                        frame_error_d = 1'b1;
                        error_code_d  = ERR_NIBBLE;
                        state_d       = S_HUNT;
                    end
                end
                S_POST: begin
                    if (is_sync) begin
                        state_d = S_STATUS;
                    end else if (is_pause) begin
                        pause_ticks_d = p;
                        pause_valid_d = 1'b1;
                        state_d       = S_HUNT;
                    end else begin
                        frame_error_d = 1'b1;
                        error_code_d  = ERR_POST;
                        state_d       = S_HUNT;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (timeout) begin
            frame_error_d = 1'b1;
            error_code_d  = ERR_TIMEOUT;
            state_d       = S_IDLE;
            clk_cnt_d     = '0;
            tick_cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_rx or negedge reset_n_rx) begin
        if (!reset_n_rx) begin
            state_q       <= S_IDLE;
            s1_q          <= 1'b1;
            s2_q          <= 1'b1;
            s3_q          <= 1'b1;
            fall_q        <= 1'b0;
            clk_cnt_q     <= '0;
            tick_cnt_q    <= '0;
            idx_q         <= '0;
            status_sh_q   <= '0;
            data_sh_q     <= '0;
            frame_valid_q <= 1'b0;
            status_out_q  <= '0;
            data_out_q    <= '0;
            crc_out_q     <= '0;
            serial_bit2_q <= 1'b0;
            serial_bit3_q <= 1'b0;
            pause_valid_q <= 1'b0;
            pause_ticks_q <= '0;
            frame_error_q <= 1'b0;
            error_code_q  <= '0;
        end else begin
            state_q       <= state_d;
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            s3_q          <= s3_d;
            fall_q        <= fall_d;
            clk_cnt_q     <= clk_cnt_d;
            tick_cnt_q    <= tick_cnt_d;
            idx_q         <= idx_d;
            status_sh_q   <= status_sh_d;
            data_sh_q     <= data_sh_d;
            frame_valid_q <= frame_valid_d;
            status_out_q  <= status_out_d;
            data_out_q    <= data_out_d;
            crc_out_q     <= crc_out_d;
            serial_bit2_q <= serial_bit2_d;
            serial_bit3_q <= serial_bit3_d;
            pause_valid_q <= pause_valid_d;
            pause_ticks_q <= pause_ticks_d;
            frame_error_q <= frame_error_d;
            error_code_q  <= error_code_d;
        end
    end

    assign frame_valid = frame_valid_q;
    assign status_out  = status_out_q;
    assign data_out    = data_out_q;
    assign crc_out     = crc_out_q;
    assign serial_bit2 = serial_bit2_q;
    assign serial_bit3 = serial_bit3_q;
    assign pause_valid = pause_valid_q;
    assign pause_ticks = pause_ticks_q;
    assign frame_error = frame_error_q;
    assign error_code  = error_code_q;

endmodule

// File: tb/tb_sent_rx_pulse_decoder.sv
// Directed bench for sent_rx_pulse_decoder: table of clean frames plus hand-built
// sequences for rounding, errors, pause, timeout and mid-frame reset.
module tb_sent_rx_pulse_decoder;

    localparam int SYNC = 56 * 8;

    logic        clk_rx = 1'b0;
    logic        reset_n_rx;
    logic        sent_in;
    logic        frame_valid;
    logic [3:0]  status_out;
    logic [23:0] data_out;
    logic [3:0]  crc_out;
    logic        serial_bit2;
    logic        serial_bit3;
    logic        pause_valid;
    logic [9:0]  pause_ticks;
    logic        frame_error;
    logic [2:0]  error_code;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int fv_cnt = 0, pv_cnt = 0, fe_cnt = 0;
    int fv_cyc = 0, pv_cyc = 0;
    int last_edge_k = 0;
    int fv0, fe0, pv0;

    sent_rx_pulse_decoder #(
        .TICK_CLKS(8),
        .NIBBLES  (6),
        .PAUSE_EN (1'b1)
    ) dut (
        .clk_rx     (clk_rx),
        .reset_n_rx (reset_n_rx),
        .sent_in    (sent_in),
        .frame_valid(frame_valid),
        .status_out (status_out),
        .data_out   (data_out),
        .crc_out    (crc_out),
        .serial_bit2(serial_bit2),
        .serial_bit3(serial_bit3),
        .pause_valid(pause_valid),
        .pause_ticks(pause_ticks),
        .frame_error(frame_error),
        .error_code (error_code)
    );

    always #5 clk_rx = ~clk_rx;

    always @(posedge clk_rx) cyc <= cyc + 1;

    always @(negedge clk_rx) begin
        if (frame_valid) begin
            fv_cnt++;
            fv_cyc = cyc;
        end
        if (pause_valid) begin
            pv_cnt++;
            pv_cyc = cyc;
        end
        if (frame_error) fe_cnt++;
    end

    typedef struct {
        logic [3:0]  st;
        logic [23:0] dat;
        logic [3:0]  crc;
        int          extra;
        logic [23:0] exp_dat;
        logic        exp_b2;
        logic        exp_b3;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One falling edge, then clks cycles until the next pulse starts.
    task automatic pulse(input int clks);
        int lo;
        lo = (clks >= 64) ? 32 : clks / 2;
        sent_in = 1'b0;
        last_edge_k = cyc;
        repeat (lo) @(negedge clk_rx);
        sent_in = 1'b1;
        repeat (clks - lo) @(negedge clk_rx);
    endtask

    task automatic nib_pulse(input logic [3:0] v, input int extra);
        pulse((12 + int'(v)) * 8 + extra);
    endtask

    task automatic send_frame(input logic [3:0] st, input logic [23:0] dat,
                              input logic [3:0] crc, input int extra, input int tail);
        nib_pulse(st, 0);
        for (int i = 0; i < 6; i++) nib_pulse(dat[23-4*i -: 4], (i == 0) ? extra : 0);
        nib_pulse(crc, 0);
        pulse(tail);
    endtask

    task automatic check_frame(input string tag, input int f0, input int e0,
                               input logic [3:0] st, input logic [23:0] dat, input logic [3:0] crc,
                               input logic b2, input logic b3);
        chk({tag, " fv_count"}, 32'(fv_cnt - f0), 32'd1);
        chk({tag, " fe_count"}, 32'(fe_cnt - e0), 32'd0);
        chk({tag, " data_out"}, 32'(data_out), 32'(dat));
        chk({tag, " status_out"}, 32'(status_out), 32'(st));
        chk({tag, " crc_out"}, 32'(crc_out), 32'(crc));
        chk({tag, " serial_bit2"}, 32'(serial_bit2), 32'(b2));
        chk({tag, " serial_bit3"}, 32'(serial_bit3), 32'(b3));
        chk({tag, " fv_latency"}, 32'(fv_cyc - last_edge_k), 32'd4);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " frame_valid"}, 32'(frame_valid), 32'd0);
        chk({tag, " status_out"}, 32'(status_out), 32'd0);
        chk({tag, " data_out"}, 32'(data_out), 32'd0);
        chk({tag, " crc_out"}, 32'(crc_out), 32'd0);
        chk({tag, " serial_bits"}, 32'({serial_bit3, serial_bit2}), 32'd0);
        chk({tag, " pause_valid"}, 32'(pause_valid), 32'd0);
        chk({tag, " pause_ticks"}, 32'(pause_ticks), 32'd0);
        chk({tag, " frame_error"}, 32'(frame_error), 32'd0);
        chk({tag, " error_code"}, 32'(error_code), 32'd0);
    endtask

    initial begin
        // st, dat, crc, extra clocks on first data nibble, expected data, status[2], status[3]
        vecs[0] = '{4'h5, 24'h37A0F1, 4'h9,  0, 24'h37A0F1, 1'b1, 1'b0};
        vecs[1] = '{4'hA, 24'h000000, 4'h0,  3, 24'h000000, 1'b0, 1'b1};
        vecs[2] = '{4'hF, 24'h000000, 4'hF,  4, 24'h100000, 1'b1, 1'b1};
        vecs[3] = '{4'h0, 24'hFEDCBA, 4'h3,  0, 24'hFEDCBA, 1'b0, 1'b0};
        vecs[4] = '{4'hC, 24'h012345, 4'h6, -4, 24'h012345, 1'b1, 1'b1};

        reset_n_rx = 1'b0;
        sent_in    = 1'b1;
        repeat (5) @(negedge clk_rx);
        check_zero("reset");
        reset_n_rx = 1'b1;
        repeat (5) @(negedge clk_rx);

        pulse(SYNC);
        for (int unsigned i = 0; i < 5; i++) begin
            fv0 = fv_cnt;
            fe0 = fe_cnt;
            send_frame(vecs[i].st, vecs[i].dat, vecs[i].crc, vecs[i].extra, SYNC);
            check_frame($sformatf("vec%0d", i), fv0, fe0, vecs[i].st, vecs[i].exp_dat,
                        vecs[i].crc, vecs[i].exp_b2, vecs[i].exp_b3);
        end

        // Out-of-range data nibble (30 ticks), then recovery
        fv0 = fv_cnt;
        fe0 = fe_cnt;
        nib_pulse(4'h5, 0);
        nib_pulse(4'h3, 0);
        pulse(30 * 8);
        pulse(SYNC);
        chk("bad_nib fe_count", 32'(fe_cnt - fe0), 32'd1);
        chk("bad_nib error_code", 32'(error_code), 32'd1);
        chk("bad_nib fv_count", 32'(fv_cnt - fv0), 32'd0);
        fv0 = fv_cnt;
        fe0 = fe_cnt;
        send_frame(4'h6, 24'h123456, 4'h7, 0, SYNC);
        check_frame("after_bad_nib", fv0, fe0, 4'h6, 24'h123456, 4'h7, 1'b1, 1'b0);

        // Legal 200-tick pause, then normal frame
        fv0 = fv_cnt;
        fe0 = fe_cnt;
        send_frame(4'h2, 24'hABCDEF, 4'h4, 0, 200 * 8);
        check_frame("pre_pause", fv0, fe0, 4'h2, 24'hABCDEF, 4'h4, 1'b0, 1'b0);
        pv0 = pv_cnt;
        pulse(SYNC);
        chk("pause pv_count", 32'(pv_cnt - pv0), 32'd1);
        chk("pause pause_ticks", 32'(pause_ticks), 32'd200);
        chk("pause pv_latency", 32'(pv_cyc - last_edge_k), 32'd4);
        fv0 = fv_cnt;
        fe0 = fe_cnt;
        send_frame(4'h1, 24'h0F0F0F, 4'hE, 0, SYNC);
        check_frame("after_pause", fv0, fe0, 4'h1, 24'h0F0F0F, 4'hE, 1'b0, 1'b0);

        // 800-tick post-CRC pulse is too long for a pause
        fv0 = fv_cnt;
        fe0 = fe_cnt;
        send_frame(4'h3, 24'h111111, 4'h2, 0, 800 * 8);
        check_frame("pre_long_pause", fv0, fe0, 4'h3, 24'h111111, 4'h2, 1'b0, 1'b0);
        pv0 = pv_cnt;
        pulse(SYNC);
        chk("long_pause fe_count", 32'(fe_cnt - fe0), 32'd1);
        chk("long_pause error_code", 32'(error_code), 32'd4);
        chk("long_pause pv_count", 32'(pv_cnt - pv0), 32'd0);
        chk("long_pause pause_ticks_held", 32'(pause_ticks), 32'd200);
        fv0 = fv_cnt;
        fe0 = fe_cnt;
        send_frame(4'h7, 24'h55AA55, 4'h1, 0, SYNC);
        check_frame("after_long_pause", fv0, fe0, 4'h7, 24'h55AA55, 4'h1, 1'b1, 1'b0);

        // Sync after three data nibbles re-syncs straight into STATUS
        fe0 = fe_cnt;
        fv0 = fv_cnt;
        nib_pulse(4'h4, 0);
        nib_pulse(4'h1, 0);
        nib_pulse(4'h2, 0);
        nib_pulse(4'h3, 0);
        pulse(SYNC);
        send_frame(4'h8, 24'h765432, 4'hB, 0, SYNC);
        chk("resync fe_count", 32'(fe_cnt - fe0), 32'd1);
        chk("resync error_code", 32'(error_code), 32'd2);
        check_frame("after_resync", fv0, fe0 + 1, 4'h8, 24'h765432, 4'hB, 1'b0, 1'b1);

        // Line held high for 1100 ticks mid-DATA
        fe0 = fe_cnt;
        fv0 = fv_cnt;
        nib_pulse(4'h9, 0);
        nib_pulse(4'h1, 0);
        pulse(1100 * 8);
        chk("timeout fe_count", 32'(fe_cnt - fe0), 32'd1);
        chk("timeout error_code", 32'(error_code), 32'd3);
        chk("timeout fv_count", 32'(fv_cnt - fv0), 32'd0);
        pulse(SYNC);
        fv0 = fv_cnt;
        fe0 = fe_cnt;
        send_frame(4'hC, 24'h2468AC, 4'h5, 0, SYNC);
        check_frame("after_timeout", fv0, fe0, 4'hC, 24'h2468AC, 4'h5, 1'b1, 1'b1);

        // Reset asserted in the middle of a data nibble
        fv0 = fv_cnt;
        fe0 = fe_cnt;
        pv0 = pv_cnt;
        nib_pulse(4'h6, 0);
        nib_pulse(4'h2, 0);
        nib_pulse(4'h8, 0);
        sent_in = 1'b0;
        repeat (20) @(negedge clk_rx);
        reset_n_rx = 1'b0;
        repeat (3) @(negedge clk_rx);
        check_zero("mid_reset");
        sent_in = 1'b1;
        repeat (5) @(negedge clk_rx);
        reset_n_rx = 1'b1;
        repeat (300) @(negedge clk_rx);
        chk("mid_reset fv_count", 32'(fv_cnt - fv0), 32'd0);
        chk("mid_reset fe_count", 32'(fe_cnt - fe0), 32'd0);
        chk("mid_reset pv_count", 32'(pv_cnt - pv0), 32'd0);
        pulse(SYNC);
        fv0 = fv_cnt;
        fe0 = fe_cnt;
        send_frame(4'h5, 24'h37A0F1, 4'h9, 0, SYNC);
        check_frame("after_reset", fv0, fe0, 4'h5, 24'h37A0F1, 4'h9, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
